// File: rtl/kim_stream_checker_pkg.sv
// Shared encodings for the kim stream models: FSM states, ready modes, LFSR polynomial.
package kim_stream_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    RM_ALWAYS  = 2'd0,
    RM_HALF    = 2'd1,
    RM_QUARTER = 2'd2,
    RM_ALT     = 2'd3
  } ready_mode_e;

  // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/kim_stream_checker_lfsr.sv
// 16-bit Galois LFSR, advances when en is high; seed reloaded only by reset.
module kim_lfsr16
  import kim_stream_checker_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] o_lfsr
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign o_lfsr = lfsr_q;

endmodule

// File: rtl/kim_stream_checker.sv
// Stream consumer: programmable backpressure, checks beats against 0,1,2,...
// and reports completion, error count and the first failing beat.
module kim_stream_checker
  import kim_stream_checker_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          CNT_W     = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic [CNT_W-1:0]  i_num,
  input  logic [1:0]        i_ready_mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              o_idle,
  output logic              o_done,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [CNT_W-1:0]  o_rx_cnt,
  output logic [CNT_W-1:0]  o_first_err_idx,
  output logic [DATA_W-1:0] o_first_err_data
);

  state_e             state_q, state_d;
  ready_mode_e        mode_q, mode_eff;
  logic [CNT_W-1:0]   num_q, rx_cnt_q, err_cnt_q, first_idx_q;
  logic [DATA_W-1:0]  first_dat_q, exp_dat;
  logic               s_ready_q, idle_q, done_q, err_q, alt_q;
  logic               accept, hs, last_beat, mask, lfsr_en;
  logic [15:0]        lfsr;
  logic               unused_lfsr;

  assign hs        = s_valid & s_ready_q;
  assign last_beat = (rx_cnt_q == num_q - CNT_W'(1));
  assign exp_dat   = DATA_W'(rx_cnt_q);
  assign lfsr_en   = (state_d == S_RUN);
  assign unused_lfsr = ^lfsr[15:2];

  kim_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en     (lfsr_en),
    .o_lfsr (lfsr)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_run) begin
          accept  = 1'b1;
          state_d = (i_num == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (hs && last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The first RUN cycle's ready is computed at the accepting edge, before mode_q loads
  always_comb begin
    mode_eff = accept ? ready_mode_e'(i_ready_mode) : mode_q;
    case (mode_eff)
      RM_ALWAYS:  mask = 1'b1;
      RM_HALF:    mask = lfsr[0];
      RM_QUARTER: mask = lfsr[0] & lfsr[1];
      default:    mask = alt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= RM_ALWAYS;
      num_q       <= '0;
      rx_cnt_q    <= '0;
      err_cnt_q   <= '0;
      first_idx_q <= '0;
      first_dat_q <= '0;
      s_ready_q   <= 1'b0;
      idle_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      alt_q       <= 1'b1;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d == S_RUN) & mask;
      idle_q    <= (state_d == S_IDLE);
      done_q    <= (state_d == S_DONE);
      alt_q     <= (state_d == S_RUN) ? ~alt_q : 1'b1;
      if (accept) begin
        num_q       <= i_num;
        mode_q      <= ready_mode_e'(i_ready_mode);
        rx_cnt_q    <= '0;
        err_cnt_q   <= '0;
        first_idx_q <= '0;
        first_dat_q <= '0;
        err_q       <= 1'b0;
      end else if (state_q == S_RUN && hs) begin
        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
        if (s_data != exp_dat) begin
          err_q <= 1'b1;
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
          if (!err_q) begin
            first_idx_q <= rx_cnt_q;
            first_dat_q <= s_data;
          end
        end
      end
    end
  end

  assign s_ready          = s_ready_q;
  assign o_idle           = idle_q;
  assign o_done           = done_q;
  assign o_err            = err_q;
  assign o_err_cnt        = err_cnt_q;
  assign o_rx_cnt         = rx_cnt_q;
  assign o_first_err_idx  = first_idx_q;
  assign o_first_err_data = first_dat_q;

endmodule

// File: tb/tb_kim_stream_checker.sv
// Scoreboard bench for kim_stream_checker: run results queued at start, checked at o_done.
module tb_kim_stream_checker;
  localparam int DW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst, i_run, s_valid, s_ready;
  logic [CW-1:0] i_num;
  logic [1:0]    i_ready_mode;
  logic [DW-1:0] s_data;
  logic          o_idle, o_done, o_err;
  logic [CW-1:0] o_err_cnt, o_rx_cnt, o_first_err_idx;
  logic [DW-1:0] o_first_err_data;

  always #5 clk = ~clk;

  kim_stream_checker #(.DATA_W(DW), .CNT_W(CW), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_num(i_num), .i_ready_mode(i_ready_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .o_idle(o_idle), .o_done(o_done), .o_err(o_err), .o_err_cnt(o_err_cnt),
    .o_rx_cnt(o_rx_cnt), .o_first_err_idx(o_first_err_idx),
    .o_first_err_data(o_first_err_data)
  );

  typedef struct {
    int rx;
    int err;
    int ecnt;
    int fidx;
    int fdat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, s_ready, 0);
    chk({tag, "_idle"}, o_idle, 1);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_rx"}, o_rx_cnt, 0);
    chk({tag, "_ecnt"}, o_err_cnt, 0);
    chk({tag, "_fidx"}, o_first_err_idx, 0);
    chk({tag, "_fdat"}, o_first_err_data, 0);
  endtask

  // One run: offers beats 0..num (one beyond num), beat bad_idx carries bad_val.
  task automatic do_run(input int num, input int mode, input int bad_idx, input int bad_val,
                        input int vpct, input int rerun_cyc, input int rst_after,
                        input bit check_alt, output int rdy_o, output int cyc_o);
    int   hs_n = 0;
    int   cyc = 0;
    int   rdy_n = 0;
    int   idx = 0;
    bit   done = 0;
    bit   hold = 0;
    exp_t e;
    if (rst_after < 0) begin
      e.ecnt = (bad_idx >= 0 && bad_idx < num) ? 1 : 0;
      e.rx   = num;
      e.err  = e.ecnt;
      e.fidx = e.ecnt ? bad_idx : 0;
      e.fdat = e.ecnt ? bad_val : 0;
      sb.push_back(e);
    end
    @(negedge clk);
    i_run = 1'b1; i_num = CW'(num); i_ready_mode = 2'(mode); s_valid = 1'b0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      i_run = (cyc == rerun_cyc);
      if (i_run) i_num = 2;
      if (o_done) begin
        done = 1;
        if (mode == 0 && vpct == 100) chk("done_cycle", cyc, num + 1);
        chk("hs_total", hs_n, num);
        chk("rdy_at_done", s_ready, 0);
        chk("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rx_cnt", o_rx_cnt, e.rx);
          chk("err", o_err, e.err);
          chk("err_cnt", o_err_cnt, e.ecnt);
          chk("first_idx", o_first_err_idx, e.fidx);
          chk("first_dat", o_first_err_data, e.fdat);
        end
        s_valid = 1'b1;
        s_data  = DW'(idx);
        @(negedge clk);
        chk("done_1cyc", o_done, 0);
        chk("idle_after", o_idle, 1);
        chk("no_extra_beat", o_rx_cnt, num);
        s_valid = 1'b0;
      end else begin
        if (s_ready) rdy_n++;
        if (check_alt) chk("alt_ready", s_ready, cyc % 2);
        if (!hold) s_valid = (idx <= num) && ($urandom_range(99) < vpct);
        s_data = (idx == bad_idx) ? DW'(bad_val) : DW'(idx);
        hold = s_valid & ~s_ready;
        if (s_valid && s_ready) begin
          hs_n++;
          idx++;
        end
        if (rst_after >= 0 && hs_n == rst_after) begin
          @(negedge clk);
          rst = 1'b1; s_valid = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          chk_reset_vals("midrun_rst");
          done = 1;
        end
      end
    end
    chk("run_finished", done, 1);
    rdy_o = rdy_n;
    cyc_o = cyc;
  endtask

  int rdy, cyc;

  initial begin
    rst = 1'b1; i_run = 1'b0; i_num = '0; i_ready_mode = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // mode 0, clean 8-beat run, back-to-back
    do_run(8, 0, -1, 0, 100, -1, -1, 0, rdy, cyc);
    // mode 0, beat 5 corrupted, 17 beats offered
    do_run(16, 0, 5, 99, 100, -1, -1, 0, rdy, cyc);
    // zero-length run
    do_run(0, 0, -1, 0, 100, -1, -1, 0, rdy, cyc);
    chk("num0_no_ready", rdy, 0);
    // mode 1, random source, long run, duty ~50%
    do_run(1000, 1, -1, 0, 70, -1, -1, 0, rdy, cyc);
    chk("duty_m1_in_range", (rdy * 100 >= cyc * 38) && (rdy * 100 <= cyc * 62), 1);
    // mode 2, duty ~25%
    do_run(300, 2, -1, 0, 80, -1, -1, 0, rdy, cyc);
    chk("duty_m2_in_range", (rdy * 100 >= cyc * 15) && (rdy * 100 <= cyc * 35), 1);
    // mode 3 alternation, reset after 4 beats, then short clean run
    do_run(10, 3, -1, 0, 100, -1, 4, 1, rdy, cyc);
    do_run(3, 3, -1, 0, 100, -1, -1, 1, rdy, cyc);
    // second i_run mid-run is ignored
    do_run(6, 0, -1, 0, 100, 3, -1, 0, rdy, cyc);
    chk("rerun_total_cycles", cyc, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
